// File: rtl/lfsr_step_ctrl_if.sv
// Control and status bundle for the LFSR step controller.
// The master drives buttons, seed and rate; the slave reports state.
interface lfsr_step_ctrl_if;
    logic       btn_start;
    logic       btn_stop;
    logic       btn_step;
    logic       seed_we;
    logic [7:0] seed;
    logic [2:0] rate_sel;
    logic [7:0] state_out;
    logic       running;
    logic       step_pulse;
    logic       period_valid;
    logic [8:0] period;

    modport master (
        output btn_start,
        output btn_stop,
        output btn_step,
        output seed_we,
        output seed,
        output rate_sel,
        input  state_out,
        input  running,
        input  step_pulse,
        input  period_valid,
        input  period
    );

    modport slave (
        input  btn_start,
        input  btn_stop,
        input  btn_step,
        input  seed_we,
        input  seed,
        input  rate_sel,
        output state_out,
        output running,
        output step_pulse,
        output period_valid,
        output period
    );
endinterface

// File: rtl/lfsr_step_ctrl.sv
// LFSR sequencing controller: run/pause/step/seed plus period measurement.
// The state register drives the LEDs and digit decoders directly.
module lfsr_step_ctrl #(
    parameter int BASE_DIV = 1000000,
    parameter int DIV_W    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    lfsr_step_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED
    } fsm_t;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_SEED,
        OP_STOP,
        OP_STEP,
        OP_START,
        OP_TICK
    } op_t;

    fsm_t             fsm_q;
    op_t              op;
    logic [7:0]       lfsr_q;
    logic [7:0]       ref_q;
    logic [7:0]       nxt;
    logic [7:0]       seed_fix;
    logic [DIV_W-1:0] pre_q;
    logic [DIV_W-1:0] term;
    logic [8:0]       cnt_q;
    logic [8:0]       cnt_inc;
    logic [8:0]       period_q;
    logic             pv_q;
    logic             run_q;
    logic             pulse_q;
    logic             is_run;
    logic             fire;
    logic             adv;

    assign is_run   = (fsm_q == RUN);
    assign term     = (DIV_W'(BASE_DIV) << bus.rate_sel) - DIV_W'(1);
    assign fire     = (pre_q >= term);
    assign seed_fix = (bus.seed == 8'h00) ? 8'h01 : bus.seed;
    assign cnt_inc  = (cnt_q == 9'h1ff) ? cnt_q : cnt_q + 9'd1;

    // Next LFSR value; the all-zero lock-up state escapes to 0x01.
    always_comb begin
        nxt = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[4], lfsr_q[7:1]};
        if (lfsr_q == 8'h00)
            nxt = 8'h01;
    end

    // Pick this cycle's action; a button that is ignored falls through.
    always_comb begin
        op = OP_NONE;
        if (bus.seed_we)
            op = OP_SEED;
        else if (bus.btn_stop && is_run)
            op = OP_STOP;
        else if (bus.btn_step && !is_run)
            op = OP_STEP;
        else if (bus.btn_start && !is_run)
            op = OP_START;
        else if (is_run)
            op = OP_TICK;
    end

    assign adv = (op == OP_STEP) || (op == OP_TICK && fire);

    // State register, FSM, prescaler and period measurement.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q    <= IDLE;
            lfsr_q   <= 8'h01;
            ref_q    <= 8'h01;
            pre_q    <= '0;
            cnt_q    <= '0;
            period_q <= '0;
            pv_q     <= 1'b0;
            run_q    <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            pulse_q <= adv;
            unique case (op)
                OP_SEED: begin
                    lfsr_q <= seed_fix;
                    ref_q  <= seed_fix;
                    pre_q  <= '0;
                    cnt_q  <= '0;
                    pv_q   <= 1'b0;
                end
                OP_STOP: begin
                    fsm_q <= PAUSED;
                    run_q <= 1'b0;
                    pre_q <= '0;
                end
                OP_START: begin
                    fsm_q <= RUN;
                    run_q <= 1'b1;
                    pre_q <= '0;
                    ref_q <= lfsr_q;
                    cnt_q <= '0;
                    pv_q  <= 1'b0;
                end
                OP_TICK: begin
                    if (fire)
                        pre_q <= '0;
                    else
                        pre_q <= pre_q + DIV_W'(1);
                end
                default: begin
                end
            endcase
            if (adv) begin
                lfsr_q <= nxt;
                cnt_q  <= cnt_inc;
                if (nxt == ref_q && !pv_q) begin
                    period_q <= cnt_inc;
                    pv_q     <= 1'b1;
                end
            end
        end
    end

    assign bus.state_out    = lfsr_q;
    assign bus.running      = run_q;
    assign bus.step_pulse   = pulse_q;
    assign bus.period_valid = pv_q;
    assign bus.period       = period_q;

endmodule
